// File: rtl/seq_checker.sv
// Receive-side monitor for an incrementing sequence stream.
// Locks on LOCK_N good samples, flags mismatches, drops lock on LOSS_N bad.
module seq_checker #(
    parameter int WIDTH  = 3,
    parameter int LOCK_N = 3,
    parameter int LOSS_N = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             seq_valid,
    input  logic [WIDTH-1:0] seq_in,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] expected
);

    localparam int GW = $clog2(LOCK_N + 1);
    localparam int BW = $clog2(LOSS_N + 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_N);
    localparam logic [BW-1:0] BAD_MAX = BW'(LOSS_N);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] exp_nx;
    logic [GW-1:0]    good_q;
    logic [GW-1:0]    good_nx;
    logic [GW-1:0]    good_inc;
    logic [BW-1:0]    bad_q;
    logic [BW-1:0]    bad_nx;
    logic [BW-1:0]    bad_inc;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nx;
    logic             pulse_q;
    logic             pulse_nx;
    logic             lock_q;
    logic             match;

    assign match    = (seq_in == exp_q);
    assign good_inc = good_q + 1'b1;
    assign bad_inc  = bad_q + 1'b1;

    // State and datapath registers; reset wins over any sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= HUNT;
            exp_q   <= '0;
            good_q  <= '0;
            bad_q   <= '0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            exp_q   <= exp_nx;
            good_q  <= good_nx;
            bad_q   <= bad_nx;
            cnt_q   <= cnt_nx;
            pulse_q <= pulse_nx;
            lock_q  <= (state_nx == LOCKED);
        end
    end

    // Next-state and prediction update for one valid sample.
    always_comb begin
        state_nx = state;
        exp_nx   = exp_q;
        good_nx  = good_q;
        bad_nx   = bad_q;
        cnt_nx   = cnt_q;
        pulse_nx = 1'b0;
        if (seq_valid) begin
            unique case (1'b1)
                (state == HUNT): begin
                    exp_nx   = seq_in + 1'b1;
                    good_nx  = '0;
                    state_nx = VERIFY;
                end
                (state == VERIFY): begin
                    exp_nx = seq_in + 1'b1;
                    if (match) begin
                        good_nx = good_inc;
                        if (good_inc == GOOD_MAX) begin
                            state_nx = LOCKED;
                            bad_nx   = '0;
                        end
                    end else begin
                        good_nx = '0;
                    end
                end
                (state == LOCKED): begin
                    // Flywheel: a wrong value is never adopted.
                    exp_nx = exp_q + 1'b1;
                    if (match) begin
                        bad_nx = '0;
                    end else begin
                        pulse_nx = 1'b1;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_nx = cnt_q + 1'b1;
                        end
                        bad_nx = bad_inc;
                        if (bad_inc == BAD_MAX) begin
                            state_nx = HUNT;
                            good_nx  = '0;
                            bad_nx   = '0;
                        end
                    end
                end
                default: begin
                    state_nx = HUNT;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        locked    = lock_q;
        err_pulse = pulse_q;
        err_count = cnt_q;
        expected  = exp_q;
    end

endmodule
